// File: rtl/wb_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter_if
// Bus bundle between four Wishbone masters, the round-robin arbiter and one
// shared Wishbone slave. Master buses are packed: master n owns slice n.
//
// Handshake: a Wishbone transfer is offered while cyc and stb are both high
// and completes in the cycle the slave raises ack (or the arbiter raises err);
// the offering side holds adr/dat/sel/we stable until then.
//
// Modports:
//   slave  - the arbiter's view: consumes master requests and slave
//            responses, drives per-master ack/err/read data and the slave bus.
//   master - the surrounding system's view (masters plus slave model).
//
// Signals:
//   m_adr_i[128] m_dat_i[128] m_sel_i[16] m_we_i[4] m_cyc_i[4] m_stb_i[4]
//   m_dat_o[32]  m_ack_o[4]   m_err_o[4]
//   s_adr_o[32]  s_dat_o[32]  s_sel_o[4]  s_we_o s_cyc_o s_stb_o
//   s_dat_i[32]  s_ack_i
// ----------------------------------------------------------------------------
interface wb_rr_arbiter_if;
  logic [127:0] m_adr_i;
  logic [127:0] m_dat_i;
  logic [31:0]  m_dat_o;
  logic [15:0]  m_sel_i;
  logic [3:0]   m_we_i;
  logic [3:0]   m_cyc_i;
  logic [3:0]   m_stb_i;
  logic [3:0]   m_ack_o;
  logic [3:0]   m_err_o;
  logic [31:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic [31:0]  s_dat_i;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic         s_cyc_o;
  logic         s_stb_o;
  logic         s_ack_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter
// Four-master round-robin Wishbone arbiter in front of one shared slave.
// The winner keeps the bus for its whole cyc tenure (no preemption), so
// block and read-modify-write sequences stay atomic. After a tenure the
// priority pointer moves to the master after the one just served.
//
// Optional watchdog, enabled by defining WB_RR_ARBITER_TIMEOUT_EN: a strobe
// left un-acked for timeout_cycles consecutive cycles is terminated with a
// one-cycle err to the owner. Without the macro m_err_o is constant zero.
//
// Parameters:
//   timeout_cycles - watchdog limit in strobe cycles (2..65535), default 255
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high reset
//   bus     - wb_rr_arbiter_if.slave bundle (masters and slave)
//   grant_o - registered one-hot grant
//   state_o - FSM state (0 = IDLE, 1 = OWNED) for debug
// ----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int timeout_cycles = 255
) (
  input  logic                clk,
  input  logic                reset,
  wb_rr_arbiter_if.slave      bus,
  output logic [3:0]          grant_o,
  output logic                state_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  localparam logic [15:0] WD_LAST = 16'(timeout_cycles - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] ptr_q,   ptr_d;

  logic [1:0] gidx;
  logic [1:0] cand;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       owned;
  logic       gnt_cyc;
  logic       stb_raw;
  logic       wd_fire;

  // Index of the current owner (grant_q is one-hot or zero).
  always_comb begin
    gidx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) gidx = 2'(i);
    end
  end

  // First requester found scanning upward from ptr_q, wrapping mod 4.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_vld && bus.m_cyc_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign owned   = (state_q == OWNED);
  assign gnt_cyc = bus.m_cyc_i[gidx];
  assign stb_raw = owned & bus.m_stb_i[gidx];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWNED;
          grant_d = 4'b0001 << pick_idx;
        end
      end
      OWNED: begin
        if (!gnt_cyc) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = gidx + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  // Fires on the timeout_cycles-th consecutive stalled strobe cycle. It
  // does not look at s_ack_i: an ack landing in this cycle is too late and
  // gets masked below, keeping ack and err mutually exclusive.
  assign wd_fire = stb_raw & (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = wd_cnt_q + 16'd1;
    if (!stb_raw || !gnt_cyc || bus.s_ack_i || wd_fire) wd_cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) wd_cnt_q <= 16'd0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_wd_last;
  assign unused_wd_last = ^WD_LAST;
  assign wd_fire        = 1'b0;
`endif

  // Slave-side request mux. cyc/stb/ack/err are additionally gated by reset
  // so a reset mid-transfer drops the slave cycle and discards a pending ack
  // in the same cycle, before the registers clear.
  assign bus.s_adr_o = bus.m_adr_i[{gidx, 5'd0} +: 32];
  assign bus.s_dat_o = bus.m_dat_i[{gidx, 5'd0} +: 32];
  assign bus.s_sel_o = bus.m_sel_i[{gidx, 2'd0} +: 4];
  assign bus.s_we_o  = bus.m_we_i[gidx];
  assign bus.s_cyc_o = ~reset & owned & gnt_cyc;
  assign bus.s_stb_o = ~reset & stb_raw & ~wd_fire;

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = {4{~reset & bus.s_ack_i & ~wd_fire}} & grant_q;
  assign bus.m_err_o = {4{~reset & wd_fire}} & grant_q;

  assign grant_o = grant_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int TO = 8;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] grant_o;
  logic       state_o;

  always #5 clk = ~clk;

  wb_rr_arbiter_if bus();

  wb_rr_arbiter #(.timeout_cycles(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .grant_o (grant_o),
    .state_o (state_o)
  );

  // Slave model: either acks every strobe at once or follows man_ack.
  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  always_comb bus.s_ack_i = auto_ack ? bus.s_stb_o : man_ack;

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic       gap_chk = 1'b0;
  int         gap_base = 0;
  int         n_ten = 0;
  int         zero_cnt = 0;
  logic [3:0] prev_g = 4'b0000;

  logic [31:0] adr_tab [4];
  logic [31:0] dat_tab [4];
  logic [3:0]  sel_tab [4];
  logic        we_tab  [4];
  logic [31:0] rd_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each new tenure pops the next expected owner; optionally checks that
  // exactly one idle bus cycle separated it from the previous tenure.
  always @(negedge clk) begin
    if (!$isunknown(grant_o)) begin
      if (grant_o == 4'b0000) begin
        zero_cnt++;
      end else begin
        if (grant_o != prev_g) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(grant_o), 32'd0);
          end else begin
            chk("grant_order", 32'(grant_o), 32'(exp_q.pop_front()));
            if (gap_chk && n_ten > gap_base) chk("idle_gap", 32'(zero_cnt), 32'd1);
          end
          n_ten++;
        end
        zero_cnt = 0;
      end
      prev_g = grant_o;
    end
  end

  function automatic int idx_of(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [3:0] cyc, input logic [3:0] stb, input logic ack,
                       input logic [3:0] eg, input logic esc, input logic ess,
                       input logic [3:0] ea, input logic [3:0] ee, input string tag);
    int k;
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    man_ack     = ack;
    rd_val      = $urandom;
    bus.s_dat_i = rd_val;
    @(negedge clk);
    chk({tag, ".grant"}, 32'(grant_o), 32'(eg));
    chk({tag, ".s_cyc"}, 32'(bus.s_cyc_o), 32'(esc));
    chk({tag, ".s_stb"}, 32'(bus.s_stb_o), 32'(ess));
    chk({tag, ".m_ack"}, 32'(bus.m_ack_o), 32'(ea));
    chk({tag, ".m_err"}, 32'(bus.m_err_o), 32'(ee));
    chk({tag, ".m_dat"}, bus.m_dat_o, rd_val);
    if (esc) begin
      k = idx_of(eg);
      chk({tag, ".s_adr"}, bus.s_adr_o, adr_tab[k]);
      chk({tag, ".s_dat"}, bus.s_dat_o, dat_tab[k]);
      chk({tag, ".s_sel"}, 32'(bus.s_sel_o), 32'(sel_tab[k]));
      chk({tag, ".s_we"},  32'(bus.s_we_o),  32'(we_tab[k]));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.m_cyc_i = 4'b0000;
    bus.m_stb_i = 4'b0000;
    man_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  // Masters in 'want' request; each does one acked transfer per tenure,
  // drops cyc for one cycle, and re-requests only when rep is set.
  task automatic run_masters(input logic [3:0] want, input bit rep);
    logic [3:0] act, drop, done;
    int k;
    act = want; drop = 4'b0000; k = 0;
    auto_ack = 1'b1;
    while (exp_q.size() != 0 && k < 200) begin
      bus.m_cyc_i = act & ~drop;
      bus.m_stb_i = act & ~drop;
      @(negedge clk);
      done = bus.m_ack_o;
      chk("ack_route", 32'(bus.m_ack_o & ~grant_o), 32'd0);
      @(posedge clk); #1;
      drop = done;
      if (!rep) act = act & ~done;
      k++;
    end
    chk("tenure_budget", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    auto_ack = 1'b0;
    bus.m_cyc_i = 4'b0000;
    bus.m_stb_i = 4'b0000;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic [3:0] e_grant;
    logic       e_scyc;
    logic       e_sstb;
    logic [3:0] e_ack;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // m2 alone, then m0+m3 from ptr=3, then m0 from ptr=0
    vecs[0]  = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000};
    vecs[6]  = '{4'b0001, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000};
    vecs[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};

    for (int i = 0; i < 4; i++) begin
      adr_tab[i] = $urandom;
      dat_tab[i] = $urandom;
      sel_tab[i] = 4'($urandom_range(0, 15));
      we_tab[i]  = 1'($urandom_range(0, 1));
      bus.m_adr_i[i*32 +: 32] = adr_tab[i];
      bus.m_dat_i[i*32 +: 32] = dat_tab[i];
      bus.m_sel_i[i*4 +: 4]   = sel_tab[i];
      bus.m_we_i[i]           = we_tab[i];
    end

    // Reset with every master requesting and the slave acking: all gated.
    reset = 1'b1;
    bus.m_cyc_i = 4'b1111;
    bus.m_stb_i = 4'b1111;
    man_ack = 1'b1;
    bus.s_dat_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.grant", 32'(grant_o), 32'd0);
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst.s_stb", 32'(bus.s_stb_o), 32'd0);
    chk("rst.m_ack", 32'(bus.m_ack_o), 32'd0);
    chk("rst.m_err", 32'(bus.m_err_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First cycle after reset is quiet; ptr=0 then picks m0.
    exp_q.push_back(4'b0001);
    cycle(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "post_rst0");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, "post_rst1");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "post_rst2");

    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].cyc, vecs[i].stb, vecs[i].ack, vecs[i].e_grant, vecs[i].e_scyc,
            vecs[i].e_sstb, vecs[i].e_ack, 4'b0000, $sformatf("vec%0d", i));
    end

    // Atomic tenure: m1 strobes three times under one cyc while m0 waits.
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    cycle(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "at0");
    for (int i = 1; i <= 3; i++)
      cycle(4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0000, $sformatf("at%0d", i));
    cycle(4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0000, "at4");
    cycle(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, "at5");
    cycle(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "at6");
    cycle(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, "at7");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, "at8");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "at9");

    // m2 tenure leaves ptr=3 so the mid-transaction reset must clear it.
    exp_q.push_back(4'b0100);
    cycle(4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "m2a");
    cycle(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000, "m2b");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, "m2c");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "m2d");

    // Reset while m1 owns the bus with a strobe being acked.
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    cycle(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "rm0");
    cycle(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0000, "rm1");
    reset = 1'b1;
    cycle(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, "rm2");
    reset = 1'b0;
    cycle(4'b1100, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "rm3");
    cycle(4'b1100, 4'b1100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000, "rm4");
    cycle(4'b1000, 4'b1000, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, "rm5");
    cycle(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "rm6");
    cycle(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b0000, "rm7");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0000, "rm8");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "rm9");

    // Stalled slave: err (when built in) on every TO-th strobe cycle, with
    // the strobe dropped and a late ack in that cycle suppressed.
    exp_q.push_back(4'b0010);
    cycle(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "wd0");
    for (int k = 1; k <= 20; k++) begin
      logic fire;
      fire = WD_ON && (k % TO == 0);
      cycle(4'b0010, 4'b0010, fire, 4'b0010, 1'b1, !fire, 4'b0000,
            fire ? 4'b0010 : 4'b0000, $sformatf("wd%0d", k));
    end
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, "wd_rel");
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "wd_idle");

    // Simultaneous m0+m3 from reset, then all four continuously.
    do_reset();
    gap_chk  = 1'b1;
    gap_base = n_ten;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    run_masters(4'b1001, 1'b0);

    gap_base = n_ten;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) exp_q.push_back(4'b0001 << i);
    run_masters(4'b1111, 1'b1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
